reaction_delay_sched: RTL

//  Schedules one reaction-time round around the 0..9 LFSR random source.

---
 rtl/reaction_delay_sched_if.sv | 25 ++
 rtl/reaction_delay_sched.sv | 127 ++++++++++++
 2 files changed

// File: rtl/reaction_delay_sched_if.sv
// rtl/reaction_delay_sched_if.sv - round control, LFSR and result signals of the reaction scheduler
interface reaction_delay_sched_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             press;
   logic [3:0]       rand_num;
   logic             lfsr_stop;
   logic             busy;
   logic             fire;
   logic [CNT_W-1:0] result;
   logic             result_valid;
   logic             false_start;
   logic             timeout;

   modport master (
      output start, press, rand_num,
      input  lfsr_stop, busy, fire, result, result_valid, false_start, timeout
   );

   modport slave (
      input  start, press, rand_num,
      output lfsr_stop, busy, fire, result, result_valid, false_start, timeout
   );
endinterface

// File: rtl/reaction_delay_sched.sv
// rtl/reaction_delay_sched.sv - one reaction-time round: random wait, fire, latency measurement
module reaction_delay_sched #(
   parameter int TICK_DIV      = 100000,
   parameter int MIN_TICKS     = 100,
   parameter int STEP_TICKS    = 50,
   parameter int TIMEOUT_TICKS = 999,
   parameter int CNT_W         = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   reaction_delay_sched_if.slave  bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_WAIT,
      S_MEASURE,
      S_DONE
   } state_t;

   state_t           state;
   logic [PW-1:0]    presc;
   logic             tick;
   logic [CNT_W-1:0] countdown;
   logic [CNT_W-1:0] resp;
   logic [3:0]       rand_clamped;
   logic [CNT_W-1:0] wait_load;

   assign tick = (presc == PW'(TICK_DIV - 1));

   // The LFSR nominally yields 0..9; anything above is treated as the longest wait.
   always_comb begin
      rand_clamped = (bus.rand_num > 4'd9) ? 4'd9 : bus.rand_num;
      wait_load    = CNT_W'(MIN_TICKS) + CNT_W'(rand_clamped) * CNT_W'(STEP_TICKS);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= S_IDLE;
         presc            <= '0;
         countdown        <= '0;
         resp             <= '0;
         bus.lfsr_stop    <= 1'b0;
         bus.busy         <= 1'b0;
         bus.fire         <= 1'b0;
         bus.result       <= '0;
         bus.result_valid <= 1'b0;
         bus.false_start  <= 1'b0;
         bus.timeout      <= 1'b0;
      end else begin
         bus.result_valid <= 1'b0;

         if (state == S_IDLE || tick) begin
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state           <= S_CAPTURE;
                  bus.false_start <= 1'b0;
                  bus.timeout     <= 1'b0;
                  bus.lfsr_stop   <= 1'b1;
                  bus.busy        <= 1'b1;
               end
            end

            // LFSR has been frozen for this cycle, so rand_num is stable to sample.
            S_CAPTURE: begin
               countdown <= wait_load;
               presc     <= '0;
               state     <= S_WAIT;
            end

            S_WAIT: begin
               if (bus.press) begin
                  bus.false_start <= 1'b1;
                  bus.lfsr_stop   <= 1'b0;
                  state           <= S_DONE;
               end else if (countdown == '0) begin
                  bus.fire      <= 1'b1;
                  bus.lfsr_stop <= 1'b0;
                  presc         <= '0;
                  resp          <= '0;
                  state         <= S_MEASURE;
               end else if (tick) begin
                  countdown <= countdown - 1'b1;
               end
            end

            // A press on the timeout cycle still counts as a valid response.
            S_MEASURE: begin
               if (bus.press) begin
                  bus.result       <= resp;
                  bus.result_valid <= 1'b1;
                  bus.fire         <= 1'b0;
                  state            <= S_DONE;
               end else if (resp == CNT_W'(TIMEOUT_TICKS)) begin
                  bus.timeout <= 1'b1;
                  bus.fire    <= 1'b0;
                  state       <= S_DONE;
               end else if (tick) begin
                  resp <= resp + 1'b1;
               end
            end

            S_DONE: begin
               if (!bus.press) begin
                  bus.busy <= 1'b0;
                  state    <= S_IDLE;
               end
            end

            default: begin
               bus.busy      <= 1'b0;
               bus.fire      <= 1'b0;
               bus.lfsr_stop <= 1'b0;
               state         <= S_IDLE;
            end
         endcase
      end
   end
endmodule
